// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: walks a ROM table of I2C write transactions, checking ACKs and retrying NACKed entries.
module i2c_cfg_seq #(
  parameter int NUM_REGS   = 11,
  parameter int NUM_BYTES  = 3,
  parameter int AW         = 4,
  parameter int CLK_DIV    = 125,
  parameter int GAP_Q      = 8,
  parameter int MAX_RETRY  = 3,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                   clk_n,
  input  logic                   rst,
  input  logic                   start,
  output logic [AW-1:0]          rom_addr,
  input  logic [NUM_BYTES*8-1:0] rom_data,
  output logic                   sclk,
  inout  wire                    sdat,
  output logic                   busy,
  output logic                   finish,
  output logic                   error,
  output logic [AW-1:0]          err_idx
);
  localparam int W  = NUM_BYTES * 8;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam int GW = $clog2(GAP_Q + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t         r_state, w_nxt;
  logic [DW-1:0]  r_div;
  logic [1:0]     r_q;
  logic [2:0]     r_bit;
  logic [BW-1:0]  r_byte;
  logic [GW-1:0]  r_gap;
  logic [RW-1:0]  r_retry;
  logic [AW-1:0]  r_idx, r_err_idx;
  logic [W-1:0]   r_sh;
  logic           r_ld, r_nack, r_auto;
  logic           w_run, w_tick, w_qend, w_go, w_sda_low;
  logic           w_last_byte, w_gap_end, w_last_idx, w_retry_max;

  assign w_run       = r_state inside {S_START, S_BIT, S_ACK, S_STOP, S_GAP};
  assign w_tick      = w_run && (r_div == DW'(CLK_DIV - 1));
  assign w_qend      = w_tick && (r_q == 2'd3);
  assign w_go        = (r_state inside {S_IDLE, S_DONE, S_ERR}) && (start || r_auto);
  assign w_last_byte = r_byte == BW'(NUM_BYTES - 1);
  assign w_gap_end   = r_gap == GW'(GAP_Q - 1);
  assign w_last_idx  = r_idx == AW'(NUM_REGS - 1);
  assign w_retry_max = r_retry == RW'(MAX_RETRY);

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: w_nxt = w_go ? S_LOAD : r_state;
      S_LOAD:  w_nxt = r_ld ? S_START : S_LOAD;
      S_START: w_nxt = w_qend ? S_BIT : S_START;
      S_BIT:   w_nxt = (w_qend && r_bit == 3'd7) ? S_ACK : S_BIT;
      S_ACK:   w_nxt = !w_qend ? S_ACK : (r_nack || w_last_byte) ? S_STOP : S_BIT;
      S_STOP:  w_nxt = w_qend ? S_GAP : S_STOP;
      S_GAP:   w_nxt = !(w_tick && w_gap_end) ? S_GAP :
                       r_nack ? (w_retry_max ? S_ERR : S_LOAD) :
                       (w_last_idx ? S_DONE : S_LOAD);
      default: w_nxt = S_IDLE;
    endcase
  end

  // Bus levels are pure functions of state and quarter, so they only move on ticks
  always_comb begin
    sclk      = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      S_START: begin
        sclk      = r_q < 2'd2;
        w_sda_low = r_q != 2'd0;
      end
      S_BIT: begin
        sclk      = r_q inside {2'd1, 2'd2};
        w_sda_low = !r_sh[W-1];
      end
      S_ACK:   sclk = r_q inside {2'd1, 2'd2};
      S_STOP: begin
        sclk      = r_q != 2'd0;
        w_sda_low = r_q < 2'd2;
      end
      default: ;
    endcase
  end

  assign sdat     = w_sda_low ? 1'b0 : 1'bz;
  assign busy     = !(r_state inside {S_IDLE, S_DONE, S_ERR});
  assign finish   = r_state == S_DONE;
  assign error    = r_state == S_ERR;
  assign rom_addr = r_idx;
  assign err_idx  = r_err_idx;

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      r_auto    <= AUTO_START;
      r_div     <= '0;
      r_q       <= '0;
      r_ld      <= 1'b0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_gap     <= '0;
      r_retry   <= '0;
      r_idx     <= '0;
      r_err_idx <= '0;
      r_sh      <= '0;
      r_nack    <= 1'b0;
    end else begin
      r_auto <= 1'b0;
      r_div  <= (w_run && !w_tick) ? r_div + DW'(1) : '0;
      r_q    <= !w_run ? 2'd0 : w_tick ? r_q + 2'd1 : r_q;
      r_ld   <= (r_state == S_LOAD) && !r_ld;
      if (w_go) begin
        r_idx   <= '0;
        r_retry <= '0;
      end
      if (r_state == S_LOAD && r_ld) begin
        r_sh   <= rom_data;
        r_nack <= 1'b0;
        r_bit  <= '0;
        r_byte <= '0;
        r_gap  <= '0;
      end
      if (r_state == S_BIT && w_qend) begin
        r_sh  <= r_sh << 1;
        r_bit <= r_bit + 3'd1;
      end
      if (r_state == S_ACK && w_tick && r_q == 2'd2) r_nack <= sdat;
      if (r_state == S_ACK && w_qend) r_byte <= r_byte + BW'(1);
      if (r_state == S_GAP && w_tick) begin
        r_gap <= r_gap + GW'(1);
        if (w_gap_end) begin
          if (r_nack && !w_retry_max) r_retry <= r_retry + RW'(1);
          if (r_nack && w_retry_max) r_err_idx <= r_idx;
          if (!r_nack && !w_last_idx) begin
            r_idx   <= r_idx + AW'(1);
            r_retry <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb_i2c_cfg_seq: I2C slave model plus a transaction-level schedule model checked every cycle.
`timescale 1ns/1ps
module tb_i2c_cfg_seq;
  localparam int NR = 2, NB = 3, AW = 4, CD = 4, GQ = 4, MR = 3;

  logic               clk_n = 1'b0, rst = 1'b0, start = 1'b0;
  logic [AW-1:0]      rom_addr, err_idx;
  logic [NB*8-1:0]    rom_data;
  logic               sclk, busy, finish, error;
  logic               s_low = 1'b0;
  wire                sda;
  logic [NB*8-1:0]    rom [NR];

  assign sda = s_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign rom_data = rom[rom_addr[0]];

  i2c_cfg_seq #(.NUM_REGS(NR), .NUM_BYTES(NB), .AW(AW), .CLK_DIV(CD), .GAP_Q(GQ),
                .MAX_RETRY(MR), .AUTO_START(1'b1)) dut (
    .clk_n(clk_n), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sclk(sclk), .sdat(sda), .busy(busy), .finish(finish), .error(error), .err_idx(err_idx));

  always #5 clk_n = ~clk_n;
  int cyc = 0;
  always @(posedge clk_n) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction schedule: one record per bus attempt, derived from table and slave NACK plan
  bit         m_act = 1'b0, m_fail;
  int         m_t, m_total, m_fidx, n_att;
  int         att_start [16], att_entry [16], att_nack [16];
  logic [7:0] exp_q [$];

  task automatic build(input int ne, input int nbyte, input int ncnt);
    n_att = 0; m_fail = 1'b0; m_fidx = 0; m_total = 0;
    exp_q.delete();
    for (int e = 0; e < NR && !m_fail; e++) begin
      for (int r = 0; r <= MR; r++) begin
        bit nk;
        int nb;
        nk = (e == ne) && (r < ncnt);
        nb = nk ? nbyte + 1 : NB;
        att_start[n_att] = m_total;
        att_entry[n_att] = e;
        att_nack[n_att]  = nk ? nbyte : -1;
        for (int b = 0; b < nb; b++) exp_q.push_back(rom[e][NB*8-1-8*b -: 8]);
        m_total += 2 + (8 + 36 * nb + GQ) * CD;
        n_att++;
        if (!nk) break;
        if (r == MR) begin
          m_fail = 1'b1;
          m_fidx = e;
        end
      end
    end
  endtask

  // Slave and bus monitor state
  logic       prev_c = 1'b1, prev_s = 1'b1, s_in = 1'b0, s_hi_ok = 1'b0;
  logic [7:0] s_sh = '0;
  int         s_bits = 0, s_pos = 0, s_att = 0, s_starts = 0, s_stops = 0, s_hi_cyc = 0;

  task automatic clr_slave();
    s_in = 1'b0; s_low = 1'b0; s_hi_ok = 1'b0; prev_c = 1'b1; prev_s = 1'b1;
    s_att = 0; s_starts = 0; s_stops = 0;
  endtask

  always @(negedge clk_n) begin : mon
    logic c, s;
    bit   legal;
    int   d, k;
    c = sclk;
    s = sda;
    if (rst) begin
      if (s !== prev_s) begin
        legal = (c === prev_c) && (!c || (prev_s && !s && !s_in) || (!prev_s && s && s_in));
        chk("sda_edge_legal", legal, 1);
      end
      if (c && prev_c && prev_s && !s) begin
        s_in = 1'b1; s_bits = 0; s_pos = 0; s_starts++;
      end else if (c && prev_c && !prev_s && s) begin
        s_in = 1'b0; s_stops++; s_att++; s_hi_ok = 1'b0;
      end else if (c && !prev_c) begin
        s_hi_cyc = cyc;
        s_hi_ok  = s_in;
        if (s_in && s_bits < 8) begin
          s_sh = {s_sh[6:0], s};
          s_bits++;
          if (s_bits == 8) begin
            chk("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("byte_value", s_sh, exp_q.pop_front());
          end
        end else if (s_in) s_bits = 9;
      end else if (!c && prev_c) begin
        if (s_hi_ok) chk("scl_high_cycles", cyc - s_hi_cyc, 2 * CD);
        s_hi_ok = 1'b0;
        if (s_in && s_bits == 8) s_low = !(s_att < 16 && att_nack[s_att] == s_pos);
        else if (s_in && s_bits == 9) begin
          s_low = 1'b0; s_bits = 0; s_pos++;
        end
      end
      if (m_act && cyc >= m_t) begin
        d = cyc - m_t;
        if (d < m_total) begin
          k = 0;
          for (int i = 1; i < n_att; i++) if (att_start[i] <= d) k = i;
          chk("busy_run", busy, 1);
          chk("finish_run", finish, 0);
          chk("error_run", error, 0);
          chk("rom_addr", rom_addr, att_entry[k]);
        end else begin
          chk("busy_end", busy, 0);
          chk("finish_end", finish, !m_fail);
          chk("error_end", error, m_fail);
          if (m_fail) chk("err_idx", err_idx, m_fidx);
          chk("sclk_idle", sclk, 1);
          chk("sda_idle", sda, 1);
        end
      end
    end
    prev_c = c;
    prev_s = s;
  end

  task automatic reset_pulse(input int ne, input int nbyte, input int ncnt);
    @(negedge clk_n);
    #1 rst = 1'b0;
    m_act = 1'b0;
    clr_slave();
    #1;
    chk("rst_sclk", sclk, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_error", error, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_err_idx", err_idx, 0);
    build(ne, nbyte, ncnt);
    #6;
    m_t = cyc + 1;
    m_act = 1'b1;
    rst = 1'b1;
  endtask

  task automatic rerun(input int ne, input int nbyte, input int ncnt);
    m_act = 1'b0;
    build(ne, nbyte, ncnt);
    @(negedge clk_n);
    #1 start = 1'b1;
    m_t = cyc + 1;
    s_att = 0; s_starts = 0; s_stops = 0;
    m_act = 1'b1;
    @(negedge clk_n);
    #1 start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_n);
  endtask

  task automatic finish_run();
    wait_cyc(m_t + m_total + 3);
    chk("bytes_missing", exp_q.size(), 0);
    chk("start_count", s_starts, n_att);
    chk("stop_count", s_stops, n_att);
  endtask

  initial begin
    rom[0] = 24'h341E00;
    rom[1] = 24'h340C12;
    repeat (2) @(posedge clk_n);
    // Nominal auto-start run
    reset_pulse(-1, 0, 0);
    chk("model_total_nominal", m_total, 964);
    chk("model_bytes_nominal", exp_q.size(), 6);
    chk("model_byte0", exp_q[0], 8'h34);
    chk("model_byte5", exp_q[5], 8'h12);
    finish_run();
    // Re-run on request
    rerun(-1, 0, 0);
    finish_run();
    // Single NACK on byte 1 of entry 0, with an ignored start mid-byte
    rerun(0, 1, 1);
    chk("model_att_retry", n_att, 3);
    wait_cyc(m_t + 100);
    #1 start = 1'b1;
    @(negedge clk_n);
    #1 start = 1'b0;
    finish_run();
    // Entry 1 address always NACKed
    rerun(1, 0, 99);
    chk("model_att_exhaust", n_att, 5);
    chk("model_fail", m_fail, 1);
    finish_run();
    // Abort mid-byte, then auto-start from entry 0
    rerun(-1, 0, 0);
    wait_cyc(m_t + 300);
    reset_pulse(-1, 0, 0);
    finish_run();
    for (int it = 0; it < 6; it++) begin
      rom[0] = 24'($urandom);
      rom[1] = 24'($urandom);
      rerun(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NB - 1)),
            int'($urandom_range(0, 4)));
      finish_run();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
